maxnet_controller: RTL

- Sequences the Maxnet iteration loop around the 4-lane floating-point processing unit.
- Holds the N activation registers and drives them as the PU's num inputs.
- Pulses the PU pipeline load enables l1/l2/l3, writes back ReLU-clamped PU results, and counts nonzero activations.
- Stops when at most one activation is nonzero or an iteration cap is reached; reports the winner index.

---
 rtl/maxnet_pkg.sv | 24 ++
 rtl/maxnet_controller_relu.sv | 21 ++
 rtl/maxnet_controller.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/maxnet_pkg.sv
// Shared FSM state type, IEEE-754 single-precision field constants and lane
// addressing helper for the Maxnet controller.
package maxnet_pkg;

   localparam int unsigned FP_W = 32;
   localparam int unsigned SIGN_BIT = FP_W - 1;
   localparam logic [FP_W-1:0] EXP_MASK  = 32'h7F80_0000;
   localparam logic [FP_W-1:0] MANT_MASK = 32'h007F_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_MUL   = 3'd2,
      ST_ADD1  = 3'd3,
      ST_ADD2  = 3'd4,
      ST_CHECK = 3'd5,
      ST_DONE  = 3'd6
   } state_e;

   function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
      return lane * width;
   endfunction

endpackage

// File: rtl/maxnet_controller_relu.sv
// Combinational ReLU on one single-precision word: negatives and NaNs become +0.
module fp_relu_clamp
   import maxnet_pkg::*;
(
   input  logic [FP_W-1:0] v_i,
   output logic [FP_W-1:0] r_o
);

   logic is_nan_s;

   // +inf has a zero mantissa and therefore passes through unchanged.
   always_comb begin
      is_nan_s = ((v_i & EXP_MASK) == EXP_MASK) && ((v_i & MANT_MASK) != {FP_W{1'b0}});
      if (v_i[SIGN_BIT] || is_nan_s) begin
         r_o = {FP_W{1'b0}};
      end else begin
         r_o = v_i;
      end
   end

endmodule

// File: rtl/maxnet_controller.sv
// Maxnet iteration sequencer: owns the activation registers, pulses the PU
// stage loads, writes back clamped results and reports the surviving lane.
module maxnet_controller
   import maxnet_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int N         = 4,
   parameter int MAX_ITER  = 255,
   parameter int ITER_W    = 8,
   parameter int STAGE_CYC = 1,
   localparam int WIN_W    = (N > 1) ? $clog2(N) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [N*XLEN-1:0]   x_in,
   input  logic [N*XLEN-1:0]   pu_result,
   output logic [N*XLEN-1:0]   x_out,
   output logic                l1,
   output logic                l2,
   output logic                l3,
   output logic                busy,
   output logic                done,
   output logic                converged,
   output logic [WIN_W-1:0]    winner,
   output logic [ITER_W-1:0]   iter_count
);

   localparam int CNT_W = $clog2(N + 1);
   localparam logic [3:0] STG_LAST = 4'(STAGE_CYC - 1);
   localparam logic [ITER_W-1:0] ITER_CAP = ITER_W'(MAX_ITER);

   state_e              state_q;
   logic [3:0]          stg_q;
   logic [N*XLEN-1:0]   x_out_q;
   logic                l1_q, l2_q, l3_q, busy_q, done_q, converged_q;
   logic [WIN_W-1:0]    winner_q;
   logic [ITER_W-1:0]   iter_q;

   logic [N*XLEN-1:0]   load_relu_s;
   logic [N*XLEN-1:0]   wb_relu_s;
   logic [N-1:0]        nz_vec_s;
   logic [CNT_W-1:0]    nz_cnt_s;
   logic [WIN_W-1:0]    win_s;
   logic [3:0]          stg_nxt_s;

   for (genvar g = 0; g < N; g++) begin : g_lane
      fp_relu_clamp u_load_relu (
         .v_i (x_in[lane_lsb(g, XLEN) +: XLEN]),
         .r_o (load_relu_s[lane_lsb(g, XLEN) +: XLEN])
      );
      fp_relu_clamp u_wb_relu (
         .v_i (pu_result[lane_lsb(g, XLEN) +: XLEN]),
         .r_o (wb_relu_s[lane_lsb(g, XLEN) +: XLEN])
      );
      // Sign bit ignored so that -0 counts as zero.
      assign nz_vec_s[g] = (x_out_q[lane_lsb(g, XLEN) +: XLEN-1] != {(XLEN-1){1'b0}});
   end

   assign stg_nxt_s = stg_q + 4'd1;

   // Nonzero lane count and lowest-index nonzero lane (scanned high to low).
   always_comb begin
      nz_cnt_s = {CNT_W{1'b0}};
      win_s    = {WIN_W{1'b0}};
      for (int i = N - 1; i >= 0; i--) begin
         nz_cnt_s = nz_cnt_s + {{(CNT_W-1){1'b0}}, nz_vec_s[i]};
         win_s    = nz_vec_s[i] ? WIN_W'(i) : win_s;
      end
   end

   // Sequencer; each strobe is registered so it is high during the final cycle of its stage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         stg_q       <= 4'd0;
         x_out_q     <= {(N*XLEN){1'b0}};
         l1_q        <= 1'b0;
         l2_q        <= 1'b0;
         l3_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         converged_q <= 1'b0;
         winner_q    <= {WIN_W{1'b0}};
         iter_q      <= {ITER_W{1'b0}};
      end else begin
         l1_q   <= 1'b0;
         l2_q   <= 1'b0;
         l3_q   <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q     <= ST_LOAD;
                  busy_q      <= 1'b1;
                  converged_q <= 1'b0;
                  winner_q    <= {WIN_W{1'b0}};
                  iter_q      <= {ITER_W{1'b0}};
               end
            end
            ST_LOAD: begin
               x_out_q <= load_relu_s;
               state_q <= ST_MUL;
               stg_q   <= 4'd0;
               l1_q    <= (STG_LAST == 4'd0);
            end
            ST_MUL: begin
               if (stg_q == STG_LAST) begin
                  state_q <= ST_ADD1;
                  stg_q   <= 4'd0;
                  l2_q    <= (STG_LAST == 4'd0);
               end else begin
                  stg_q <= stg_nxt_s;
                  l1_q  <= (stg_nxt_s == STG_LAST);
               end
            end
            ST_ADD1: begin
               if (stg_q == STG_LAST) begin
                  state_q <= ST_ADD2;
                  stg_q   <= 4'd0;
                  l3_q    <= (STG_LAST == 4'd0);
               end else begin
                  stg_q <= stg_nxt_s;
                  l2_q  <= (stg_nxt_s == STG_LAST);
               end
            end
            ST_ADD2: begin
               if (stg_q == STG_LAST) begin
                  x_out_q <= wb_relu_s;
                  iter_q  <= iter_q + {{(ITER_W-1){1'b0}}, 1'b1};
                  state_q <= ST_CHECK;
                  stg_q   <= 4'd0;
               end else begin
                  stg_q <= stg_nxt_s;
                  l3_q  <= (stg_nxt_s == STG_LAST);
               end
            end
            ST_CHECK: begin
               if (nz_cnt_s <= CNT_W'(1)) begin
                  state_q     <= ST_DONE;
                  done_q      <= 1'b1;
                  converged_q <= 1'b1;
                  winner_q    <= win_s;
               end else if (iter_q == ITER_CAP) begin
                  state_q     <= ST_DONE;
                  done_q      <= 1'b1;
                  converged_q <= 1'b0;
                  winner_q    <= win_s;
               end else begin
                  state_q <= ST_MUL;
                  stg_q   <= 4'd0;
                  l1_q    <= (STG_LAST == 4'd0);
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign x_out      = x_out_q;
   assign l1         = l1_q;
   assign l2         = l2_q;
   assign l3         = l3_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign converged  = converged_q;
   assign winner     = winner_q;
   assign iter_count = iter_q;

endmodule
